// File: rtl/pmp_ram.sv
// Single-port word RAM with alignment, range and PMP fault checks, one-cycle registered response.
// Optional PMP_RAM_INIT_CLEAR_EN: zero the whole array after reset before accepting requests.
`timescale 1ns/1ps
module pmp_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic                pmp_allow_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ack_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic                busy_o
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned DepW     = $clog2(DEPTH);
  localparam int unsigned IdxW     = ADDR_W - OffW;

  typedef enum logic [1:0] {StIdle, StResp, StClear} state_e;

`ifdef PMP_RAM_INIT_CLEAR_EN
  localparam state_e ResetState = StClear;
  logic [DepW-1:0] clr_cnt_q, clr_cnt_d;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [DepW-1:0]     mem_widx;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NumBytes-1:0] mem_wbe;

  logic [IdxW-1:0]     word_idx;
  logic [DepW-1:0]     mem_idx;
  logic                misaligned;
  logic                out_of_range;
  logic [1:0]          fault_code;

  assign word_idx = addr_i[ADDR_W-1:OffW];
  assign mem_idx  = word_idx[DepW-1:0];
  // Widen before comparing so DEPTH never truncates against a narrow index.
  assign out_of_range = ({{(64-IdxW){1'b0}}, word_idx} >= 64'(DEPTH));

  generate
    if (OffW > 0) begin : g_align
      assign misaligned = |addr_i[OffW-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  always_comb begin
    fault_code = 2'd0;
    if (misaligned)        fault_code = 2'd1;
    else if (out_of_range) fault_code = 2'd2;
    else if (!pmp_allow_i) fault_code = 2'd3;
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    code_d    = code_q;
    mem_we    = 1'b0;
    mem_widx  = mem_idx;
    mem_wdata = wdata_i;
    mem_wbe   = be_i;
`ifdef PMP_RAM_INIT_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StResp;
          err_d   = (fault_code != 2'd0);
          code_d  = fault_code;
          rdata_d = '0;
          if (fault_code == 2'd0) begin
            if (we_i) mem_we  = 1'b1;
            else      rdata_d = mem_q[mem_idx];
          end
        end
      end
      StResp: state_d = StIdle;
`ifdef PMP_RAM_INIT_CLEAR_EN
      StClear: begin
        mem_we    = 1'b1;
        mem_widx  = clr_cnt_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == DepW'(DEPTH - 1)) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
    // Reset wins over everything, including a write about to be issued.
    if (rst) begin
      state_d = ResetState;
      rdata_d = '0;
      err_d   = 1'b0;
      code_d  = 2'd0;
      mem_we  = 1'b0;
`ifdef PMP_RAM_INIT_CLEAR_EN
      clr_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    rdata_q <= rdata_d;
    err_q   <= err_d;
    code_q  <= code_d;
`ifdef PMP_RAM_INIT_CLEAR_EN
    clr_cnt_q <= clr_cnt_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < int'(NumBytes); k++) begin
        if (mem_wbe[k]) mem_q[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  assign rdata_o    = rdata_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign ack_o      = (state_q == StResp);
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_pmp_ram.sv
// Self-checking bench for pmp_ram (DATA_W=32, DEPTH=1024): directed cases plus random
// traffic checked against a byte-level reference memory.
`timescale 1ns/1ps
module tb_pmp_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic        pmp_allow_i = 1'b0;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        busy_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] ref_mem   [1024];
  bit          ref_valid [1024];

  pmp_ram #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .pmp_allow_i (pmp_allow_i),
    .rdata_o     (rdata_o),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // After a clearing reset every word reads as zero; otherwise contents are unknown.
  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
`ifdef PMP_RAM_INIT_CLEAR_EN
      ref_mem[i] = '0;
      ref_valid[i] = 1'b1;
`else
      ref_valid[i] = 1'b0;
`endif
    end
  endtask

  task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input bit allow,
                       output logic [31:0] er, output bit ee, output logic [1:0] ec,
                       output bit known);
    int unsigned idx;
    idx = addr / 4;
    if (addr % 4 != 0)  ec = 2'd1;
    else if (idx >= 1024) ec = 2'd2;
    else if (!allow)    ec = 2'd3;
    else                ec = 2'd0;
    ee = (ec != 2'd0);
    er = '0;
    known = 1'b1;
    if (ec == 2'd0) begin
      if (we) begin
        for (int k = 0; k < 4; k++) if (be[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
        if (be == 4'hF) ref_valid[idx] = 1'b1;
      end else begin
        er = ref_mem[idx];
        known = ref_valid[idx];
      end
    end
  endtask

  task automatic xact(input string tag, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input bit allow);
    logic [31:0] er;
    bit          ee;
    logic [1:0]  ec;
    bit          known;
    model(we, addr, wd, be, allow, er, ee, ec, known);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy_o, 1'b0);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be; pmp_allow_i = allow;
    @(posedge clk); #1;
    req_i = 1'b0;
    chk({tag, "_ack"}, ack_o, 1'b1);
    chk({tag, "_err"}, err_o, ee);
    chk({tag, "_code"}, err_code_o, ec);
    chk({tag, "_busy"}, busy_o, 1'b1);
    if (known) chk({tag, "_rdata"}, rdata_o, er);
    @(posedge clk); #1;
    chk({tag, "_ack_drop"}, ack_o, 1'b0);
    chk({tag, "_err_hold"}, err_o, ee);
    if (known) chk({tag, "_rdata_hold"}, rdata_o, er);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_code", err_code_o, 2'd0);
    chk("rst_rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (busy_o && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_ready", busy_o, 1'b0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  be;
    bit          w, al;
    int          acks, kind, n;

    do_reset();
`ifdef PMP_RAM_INIT_CLEAR_EN
    // Hold a read request throughout the clear; it must be ignored.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h3FC; pmp_allow_i = 1'b1; be_i = 4'hF;
    n = 0; acks = 0;
    while (busy_o && n < 3000) begin
      n++;
      if (ack_o) acks++;
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    chk("clear_busy_cycles", n, 1024);
    chk("clear_no_ack", acks, 0);
    xact("clear_read_3fc", 1'b0, 32'h3FC, 32'h0, 4'hF, 1'b1);
`else
    chk("post_rst_busy", busy_o, 1'b0);
`endif

    xact("wr_deadbeef", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    xact("rd_deadbeef", 1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
    xact("wr_be5", 1'b1, 32'h10, 32'h11223344, 4'h5, 1'b1);
    xact("rd_be5", 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    chk("be5_value", ref_mem[4], 32'hDE22BE44);
    xact("fault_misalign", 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 1'b1);
    xact("fault_range", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b1);
    xact("fault_pmp", 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 1'b0);
    xact("be0_noop", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1);
    xact("rd_after_faults", 1'b0, 32'h10, 32'h0, 4'hF, 1'b1);

    // Back-to-back reads: one ack every second cycle.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; pmp_allow_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("b2b_ack", ack_o, (i % 2 == 0));
      if (ack_o) begin
        acks++;
        chk("b2b_rdata", rdata_o, 32'hDE22BE44);
      end
    end
    req_i = 1'b0;
    chk("b2b_ack_count", acks, 5);

    // Fill a window, then random traffic including faults.
    for (int i = 0; i < 64; i++) xact("fill", 1'b1, i * 4, $urandom, 4'hF, 1'b1);
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
      else if (kind == 1) a = (1024 + $urandom_range(0, 100000)) * 4;
      else                a = $urandom_range(0, 63) * 4;
      w  = $urandom_range(0, 1);
      al = ($urandom_range(0, 7) != 0);
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      xact("rand", w, a, d, be, al);
    end

    // Reset in the response cycle: ack aborted, committed write survives.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'hA5A55A5A; be_i = 4'hF;
    pmp_allow_i = 1'b1;
    ref_mem[8] = 32'hA5A55A5A; ref_valid[8] = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    chk("rstresp_ack_before", ack_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstresp_ack", ack_o, 1'b0);
    chk("rstresp_rdata", rdata_o, 32'h0);
    chk("rstresp_err", err_o, 1'b0);
`ifdef PMP_RAM_INIT_CLEAR_EN
    chk("rstresp_busy", busy_o, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_ready();
`else
    chk("rstresp_busy", busy_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
`endif
    xact("rstresp_readback", 1'b0, 32'h20, 32'h0, 4'hF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
